// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : riscv_mem_pkg                                                    |
// | Purpose  : Memory-mapped register addresses and STATUS field layout for the |
// |            data-side responder of the JPEG RISC-V core.                     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package riscv_mem_pkg;

  localparam logic [31:0] ADDR_OUTFIFO = 32'h8000_0000;
  localparam logic [31:0] ADDR_STATUS  = 32'h8000_0004;
  localparam logic [31:0] ADDR_DONE    = 32'h8000_0008;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 8;
  localparam int STATUS_COUNT_W      = 8;

endpackage : riscv_mem_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sync_fifo                                                        |
// | Purpose  : Single-clock FIFO with registered storage; no fall-through, so a |
// |            pushed word reaches the head one cycle after the push.           |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int FIFODEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(FIFODEPTH):0]   o_count
);

  localparam int                c_pw         = $clog2(FIFODEPTH);
  localparam logic [c_pw:0]     c_full_count = (c_pw+1)'(FIFODEPTH);
  localparam logic [c_pw:0]     c_cnt_one    = (c_pw+1)'(1);
  localparam logic [c_pw-1:0]   c_ptr_one    = c_pw'(1);

  logic [WIDTH-1:0] r_mem [FIFODEPTH];
  logic [c_pw-1:0]  r_wptr;
  logic [c_pw-1:0]  r_rptr;
  logic [c_pw:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_count == c_full_count);
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~w_empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + c_ptr_one;
      if (w_pop_ok)  r_rptr <= r_rptr + c_ptr_one;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : dmem_responder                                                   |
// | Purpose  : Data-side bus responder: word RAM, output stream FIFO, STATUS    |
// |            and DONE registers behind the core's single-cycle interface.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAMWORDS  = 4096,
  parameter int FIFODEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ramaddress,
  input  logic             writeram,
  input  logic [WIDTH-1:0] writeramdata,
  output logic [WIDTH-1:0] readramdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             done,
  output logic             overflow
);

  localparam int               c_ram_aw       = $clog2(RAMWORDS);
  localparam int               c_cnt_w        = $clog2(FIFODEPTH) + 1;
  localparam logic [WIDTH-1:0] c_addr_outfifo = WIDTH'(ADDR_OUTFIFO);
  localparam logic [WIDTH-1:0] c_addr_status  = WIDTH'(ADDR_STATUS);
  localparam logic [WIDTH-1:0] c_addr_done    = WIDTH'(ADDR_DONE);

  logic [WIDTH-1:0]    r_ram [RAMWORDS];
  logic                r_done;
  logic                r_overflow;

  logic [WIDTH-3:0]    w_word;
  logic [c_ram_aw-1:0] w_ram_idx;
  logic                w_sel_ram;
  logic                w_sel_fifo;
  logic                w_sel_status;
  logic                w_sel_done;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [c_cnt_w-1:0]  w_count;
  logic [WIDTH-1:0]    w_status;
  logic [WIDTH-1:0]    w_rdata;
  logic                w_unused_addr_lsbs;

  // Byte-lane bits carry no meaning on this word-only bus.
  assign w_unused_addr_lsbs = &{1'b0, ramaddress[1:0]};

  assign w_word       = ramaddress[WIDTH-1:2];
  assign w_ram_idx    = w_word[c_ram_aw-1:0];
  assign w_sel_ram    = (w_word[WIDTH-3:c_ram_aw] == '0);
  assign w_sel_fifo   = (w_word == c_addr_outfifo[WIDTH-1:2]);
  assign w_sel_status = (w_word == c_addr_status[WIDTH-1:2]);
  assign w_sel_done   = (w_word == c_addr_done[WIDTH-1:2]);

  assign w_push = writeram & w_sel_fifo;
  assign w_pop  = out_valid & out_ready;

  sync_fifo #(
    .WIDTH     (WIDTH),
    .FIFODEPTH (FIFODEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (writeramdata),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid = ~w_empty;

  // RAM is deliberately left out of reset so preloaded contents survive it.
  always_ff @(posedge clock) begin
    if (writeram & w_sel_ram) r_ram[w_ram_idx] <= writeramdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (writeram & w_sel_done)      r_done     <= 1'b1;
      if (w_push & w_full & ~w_pop)   r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_status                                       = '0;
    w_status[STATUS_FULL_BIT]                      = w_full;
    w_status[STATUS_EMPTY_BIT]                     = w_empty;
    w_status[STATUS_OVERFLOW_BIT]                  = r_overflow;
    w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W]   = STATUS_COUNT_W'(w_count);
  end

  // Reads are combinational; a same-cycle write is not yet visible here.
  always_comb begin
    w_rdata = '0;
    if (w_sel_ram)         w_rdata = r_ram[w_ram_idx];
    else if (w_sel_status) w_rdata = w_status;
    else if (w_sel_done)   w_rdata = WIDTH'(r_done);
  end

  assign readramdata = w_rdata;
  assign done        = r_done;
  assign overflow    = r_overflow;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                                |
// | Purpose  : Randomized scoreboard bench for dmem_responder with a high-level |
// |            memory/stream reference model.                                   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int          RAMWORDS = 4096;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] A_FIFO   = 32'h8000_0000;
  localparam logic [31:0] A_STAT   = 32'h8000_0004;
  localparam logic [31:0] A_DONE   = 32'h8000_0008;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ramaddress = '0;
  logic        writeram = 1'b0;
  logic [31:0] writeramdata = '0;
  logic [31:0] readramdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        done;
  logic        overflow;

  dmem_responder #(.WIDTH(32), .RAMWORDS(RAMWORDS), .FIFODEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .ramaddress   (ramaddress),
    .writeram     (writeram),
    .writeramdata (writeramdata),
    .readramdata  (readramdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: sparse RAM contents, stream occupancy and sticky flags.
  logic [31:0] ram_m [int];
  logic [31:0] sb [$];
  int          mcount = 0;
  logic        done_m = 1'b0;
  logic        ovf_m  = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wa(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  // {known, value}; unwritten RAM words are not predicted.
  function automatic logic [32:0] mread(input logic [31:0] a);
    logic [31:0] w;
    w = wa(a);
    if (w < 32'(RAMWORDS * 4)) begin
      if (ram_m.exists(int'(w[31:2]))) return {1'b1, ram_m[int'(w[31:2])]};
      return {1'b0, 32'h0};
    end
    if (w == A_STAT)
      return {1'b1, 16'h0, 8'(mcount), 5'b0, ovf_m, (mcount == 0), (mcount == DEPTH)};
    if (w == A_DONE) return {1'b1, 31'b0, done_m};
    return {1'b1, 32'h0};
  endfunction

  // One bus cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic rdy);
    logic [32:0] r;
    logic        is_push, pop, acc;
    ramaddress   = addr;
    writeram     = we;
    writeramdata = wd;
    out_ready    = rdy;
    r = mread(addr);
    @(negedge clock);
    if (r[32]) chk("readramdata", readramdata, r[31:0]);
    chk("out_valid", 32'(out_valid), 32'(mcount > 0));
    chk("done", 32'(done), 32'(done_m));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    @(posedge clock);
    is_push = we && (wa(addr) == A_FIFO);
    pop     = (mcount > 0) && rdy;
    acc     = is_push && ((mcount < DEPTH) || pop);
    if (is_push && !acc) ovf_m = 1'b1;
    if (acc) sb.push_back(wd);
    mcount = mcount + int'(acc) - int'(pop);
    if (we && wa(addr) < 32'(RAMWORDS * 4)) ram_m[int'(addr[31:2])] = wd;
    if (we && wa(addr) == A_DONE) done_m = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    writeram  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    mcount = 0;
    sb.delete();
    done_m = 1'b0;
    ovf_m  = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int g = 0; g < 4 * DEPTH && mcount > 0; g++) step(1'b0, A_STAT, 32'h0, 1'b1);
  endtask

  // Stream monitor: every handshake must deliver the oldest accepted word.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stream: got %h expected no word at %0t", out_data, $time);
        end else begin
          chk("stream", out_data, sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          cat;
    do_reset();
    step(1'b0, A_STAT, 32'h0, 1'b0);

    // RAM write then read, and read-during-write sees old data
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 32'h10, 32'h0, 1'b0);
    step(1'b1, 32'h10, 32'h0BAD_F00D, 1'b0);
    step(1'b0, 32'h13, 32'h0, 1'b0);

    // Back-to-back stream with sink ready
    step(1'b1, A_FIFO, 32'h11, 1'b1);
    step(1'b1, A_FIFO, 32'h22, 1'b1);
    step(1'b1, A_FIFO, 32'h33, 1'b1);
    step(1'b0, 32'h10, 32'h0, 1'b1);
    step(1'b0, 32'h10, 32'h0, 1'b1);

    // Fill past capacity, then drain
    for (int i = 1; i <= DEPTH + 1; i++) step(1'b1, A_FIFO, 32'(i), 1'b0);
    step(1'b0, A_STAT, 32'h0, 1'b0);
    drain();
    step(1'b0, A_STAT, 32'h0, 1'b0);

    // Push into a full FIFO while the head leaves
    for (int i = 0; i < DEPTH; i++) step(1'b1, A_FIFO, 32'h100 + 32'(i), 1'b0);
    step(1'b1, A_FIFO, 32'hAA, 1'b1);
    step(1'b0, A_STAT, 32'h0, 1'b0);
    drain();

    // Reset mid-stream keeps RAM contents
    step(1'b1, 32'h20, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, A_FIFO, 32'h500 + 32'(i), 1'b0);
    do_reset();
    step(1'b0, 32'h20, 32'h0, 1'b0);
    step(1'b0, A_STAT, 32'h0, 1'b0);

    // Decode: DONE, unmapped and out-of-range RAM
    step(1'b1, 32'h0, 32'h0000_CAFE, 1'b0);
    step(1'b1, A_DONE, 32'h0, 1'b0);
    step(1'b0, A_DONE, 32'h0, 1'b0);
    step(1'b0, 32'h8000_0010, 32'h0, 1'b0);
    step(1'b1, 32'(RAMWORDS * 4), 32'hFFFF_0000, 1'b0);
    step(1'b0, 32'(RAMWORDS * 4), 32'h0, 1'b0);
    step(1'b1, 32'h8000_0010, 32'hFFFF_1111, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      cat = int'($urandom_range(0, 9));
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else if (cat < 3) begin
        a = {20'h0, 6'($urandom_range(0, 63)), 4'h0, 2'($urandom)};
        a = {a[31:4], 2'($urandom), a[1:0]};
        step(1'($urandom), a, $urandom, 1'($urandom));
      end else if (cat < 6) begin
        step($urandom_range(0, 4) != 0, A_FIFO, $urandom, $urandom_range(0, 2) == 0);
      end else if (cat == 6) begin
        step(1'b0, A_STAT | 32'($urandom_range(0, 3)), 32'h0, 1'($urandom));
      end else if (cat == 7) begin
        step($urandom_range(0, 19) == 0, A_DONE, $urandom, 1'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 32'h8000_000C;
          1:       a = 32'h8000_0010 + 32'($urandom_range(0, 255) * 4);
          2:       a = 32'(RAMWORDS * 4) + 32'($urandom_range(0, 63) * 4);
          default: a = 32'hFFFF_FFFC;
        endcase
        step(1'($urandom), a, $urandom, 1'($urandom));
      end
    end

    drain();
    step(1'b0, A_STAT, 32'h0, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dmem_responder
`default_nettype wire
